max_cut_seq: RTL and testbench

Sequential, parametrised max-cut evaluator for an N-node undirected graph. It scans one node pair per clock and counts the edges that cross a 2-colour partition. The count is compared against a runtime threshold, and the block keeps the best cut seen since the last clear. Upstream drives it as a scoring core, either from an annealer-result sweep or a host loop, through a start/done handshake.

---
 rtl/max_cut_seq.sv | 129 ++++++++++++
 tb/tb_max_cut_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/max_cut_seq.sv
// Sequential max-cut scorer: walks one upper-triangle node pair per clock, counts crossing edges,
// compares against a threshold and tracks the best cut since the last clear.
module max_cut_seq #(
  parameter int unsigned N  = 5,
  parameter int unsigned E  = N * (N - 1) / 2,
  parameter int unsigned CW = $clog2(E + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [N-1:0]  part_i,
  input  logic [E-1:0]  adj_i,
  input  logic [CW-1:0] threshold_i,
  input  logic          clr_best_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] cut_o,
  output logic          meets_o,
  output logic [CW-1:0] best_cut_o,
  output logic [N-1:0]  best_part_o
);

  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned KW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q;
  logic [N-1:0]  part_q;
  logic [E-1:0]  adj_q;
  logic [CW-1:0] thr_q;
  logic [CW-1:0] acc_q;
  logic [IW-1:0] i_q;
  logic [IW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cut_q;
  logic          meets_q;
  logic [CW-1:0] best_cut_q;
  logic [N-1:0]  best_part_q;

  logic          hit;
  logic [CW-1:0] sum;

  // Sum including the pair under evaluation this cycle.
  always_comb begin
    hit = adj_q[k_q] & (part_q[i_q] ^ part_q[j_q]);
    sum = acc_q + CW'(hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      part_q      <= '0;
      adj_q       <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cut_q       <= '0;
      meets_q     <= 1'b0;
      best_cut_q  <= '0;
      best_part_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            part_q  <= part_i;
            adj_q   <= adj_i;
            thr_q   <= threshold_i;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= IW'(1);
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (k_q == KW'(E - 1)) begin
            cut_q   <= sum;
            meets_q <= (sum >= thr_q);
            if (sum > best_cut_q) begin
              best_cut_q  <= sum;
              best_part_q <= part_q;
            end
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            acc_q <= sum;
            k_q   <= k_q + KW'(1);
            if (j_q == IW'(N - 1)) begin
              i_q <= i_q + IW'(1);
              j_q <= i_q + IW'(2);
            end else begin
              j_q <= j_q + IW'(1);
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
      // Placed after the case so a clear beats a same-edge best update.
      if (clr_best_i) begin
        best_cut_q  <= '0;
        best_part_q <= '0;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cut_o       = cut_q;
  assign meets_o     = meets_q;
  assign best_cut_o  = best_cut_q;
  assign best_part_o = best_part_q;

endmodule

// File: tb/tb_max_cut_seq.sv
// Directed plus randomized bench for max_cut_seq (N=5 and N=4 instances).
module tb_max_cut_seq;

  logic clk;
  int   n_cmp;
  int   n_fail;

  // N = 5 instance
  logic       rst_n5, start5, clr5, busy5, done5, meets5;
  logic [4:0] part5, bp5;
  logic [9:0] adj5;
  logic [3:0] thr5, cut5, bc5;

  // N = 4 instance
  logic       rst_n4, start4, clr4, busy4, done4, meets4;
  logic [3:0] part4, bp4;
  logic [5:0] adj4;
  logic [2:0] thr4, cut4, bc4;

  int         rb_cut;
  logic [4:0] rb_part;

  max_cut_seq #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n5), .start_i(start5), .part_i(part5), .adj_i(adj5),
    .threshold_i(thr5), .clr_best_i(clr5), .busy_o(busy5), .done_o(done5), .cut_o(cut5),
    .meets_o(meets5), .best_cut_o(bc5), .best_part_o(bp5)
  );

  max_cut_seq #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start_i(start4), .part_i(part4), .adj_i(adj4),
    .threshold_i(thr4), .clr_best_i(clr4), .busy_o(busy4), .done_o(done4), .cut_o(cut4),
    .meets_o(meets4), .best_cut_o(bc4), .best_part_o(bp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count edges whose endpoints lie on different sides.
  function automatic int ref_cut(input int n, input logic [31:0] p, input logic [31:0] a);
    int k = 0;
    int c = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (a[k] && (p[i] != p[j])) c++;
        k++;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero5(input string tag);
    chk({tag, ":busy"}, 32'(busy5), 0);
    chk({tag, ":done"}, 32'(done5), 0);
    chk({tag, ":cut"}, 32'(cut5), 0);
    chk({tag, ":meets"}, 32'(meets5), 0);
    chk({tag, ":best_cut"}, 32'(bc5), 0);
    chk({tag, ":best_part"}, 32'(bp5), 0);
  endtask

  task automatic run5(input logic [4:0] p, input logic [9:0] a, input logic [3:0] th,
                      input bit clr_req, input bit glitch, input string tag);
    int lat, bcnt, extra, exp_cut;
    exp_cut = ref_cut(5, 32'(p), 32'(a));
    part5 = p; adj5 = a; thr5 = th; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    // Scramble inputs to show they were latched at accept.
    part5 = ~p; adj5 = ~a; thr5 = ~th;
    lat = 0; bcnt = 0;
    while (done5 !== 1'b1 && lat < 40) begin
      if (busy5 === 1'b1) bcnt++;
      if (clr_req && lat == 9) clr5 = 1'b1;
      if (glitch && lat == 3) start5 = 1'b1;
      @(negedge clk);
      lat++;
      clr5 = 1'b0; start5 = 1'b0;
    end
    if (busy5 === 1'b1) bcnt++;
    chk({tag, ":latency"}, 32'(lat), 10);
    chk({tag, ":busy_cycles"}, 32'(bcnt), 11);
    chk({tag, ":cut"}, 32'(cut5), 32'(exp_cut));
    chk({tag, ":meets"}, 32'(meets5), 32'(exp_cut >= int'(th)));
    if (clr_req) begin
      rb_cut = 0; rb_part = '0;
    end else if (exp_cut > rb_cut) begin
      rb_cut = exp_cut; rb_part = p;
    end
    chk({tag, ":best_cut"}, 32'(bc5), 32'(rb_cut));
    chk({tag, ":best_part"}, 32'(bp5), 32'(rb_part));
    if (glitch) start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    chk({tag, ":busy_after"}, 32'(busy5), 0);
    chk({tag, ":done_after"}, 32'(done5), 0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done5 === 1'b1) extra++;
    end
    chk({tag, ":extra_done"}, 32'(extra), 0);
  endtask

  task automatic run4(input logic [3:0] p, input logic [5:0] a, input string tag);
    int lat;
    part4 = p; adj4 = a; thr4 = 3'd2; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; part4 = ~p;
    lat = 0;
    while (done4 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 6);
    chk({tag, ":cut"}, 32'(cut4), 32'(ref_cut(4, 32'(p), 32'(a))));
    chk({tag, ":meets"}, 32'(meets4), 32'(ref_cut(4, 32'(p), 32'(a)) >= 2));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dn;
    n_cmp = 0; n_fail = 0; rb_cut = 0; rb_part = '0;
    rst_n5 = 1'b0; start5 = 1'b0; clr5 = 1'b0; part5 = '0; adj5 = '0; thr5 = '0;
    rst_n4 = 1'b0; start4 = 1'b0; clr4 = 1'b0; part4 = '0; adj4 = '0; thr4 = '0;
    repeat (3) @(negedge clk);
    rst_n5 = 1'b1; rst_n4 = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero5("reset");
    chk("reset4:cut", 32'(cut4), 0);

    run5(5'b00001, 10'h2C7, 4'd3, 1'b0, 1'b0, "basic");
    run5(5'b10001, 10'h2C7, 4'd6, 1'b0, 1'b0, "better");
    run5(5'b00001, 10'h2C7, 4'd3, 1'b0, 1'b0, "worse");
    run5(5'b01110, 10'h2C7, 4'd5, 1'b0, 1'b0, "tie");
    run5(5'b00001, 10'h2C7, 4'd2, 1'b0, 1'b1, "ignore_start");
    run5(5'b00000, 10'h2C7, 4'd0, 1'b0, 1'b0, "thr_zero");
    run5(5'b10001, 10'h2C7, 4'd4, 1'b1, 1'b0, "clr_on_done");
    run5(5'b00001, 10'h2C7, 4'd3, 1'b0, 1'b0, "after_clr");

    for (int r = 0; r < 20; r++) begin
      run5(5'($urandom), 10'($urandom), 4'($urandom_range(0, 11)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), "random");
    end

    // Asynchronous reset in the middle of a clock phase.
    @(negedge clk);
    #2 rst_n5 = 1'b0;
    #1 chk_zero5("async_rst");
    @(negedge clk);
    rst_n5 = 1'b1; rb_cut = 0; rb_part = '0;
    run5(5'b10001, 10'h2C7, 4'd5, 1'b0, 1'b0, "post_rst");

    run4(4'b0011, 6'b111111, "n4_full");

    // Abort a run with reset at scan cycle 3.
    part4 = 4'b0011; adj4 = 6'b111111; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n4 = 1'b0;
    @(negedge clk);
    rst_n4 = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done4 === 1'b1) dn++;
    end
    chk("n4_abort:done", 32'(dn), 0);
    chk("n4_abort:cut", 32'(cut4), 0);
    chk("n4_abort:busy", 32'(busy4), 0);
    run4(4'b0001, 6'b111111, "n4_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
